tx_fifo_axil_feeder: RTL and testbench
======================================

TX_FIFO_AXIL_FEEDER -- requirements
Module: tx_fifo_axil_feeder

Interface
REQ-001 Parameter C_BASE_ADDR, 32'h43C0_0000, TX FIFO slave base; DATA register at base+0x0, STATUS register at base+0x4.
REQ-002 Parameter C_POLL_GAP, 8, idle cycles between consecutive STATUS reads while FIFO reports full (range 1..255).
REQ-003 Parameter C_FULL_BIT, 0, bit index of the FULL flag in STATUS read data.
REQ-004 ACLK  in  1  single clock; all logic on rising edge.
REQ-005 ARESET  in  1  synchronous, active-high reset.
REQ-006 S_TDATA  in  32  word to push into TX FIFO.
REQ-007 S_TVALID  in  1  S_TDATA valid.
REQ-008 S_TREADY  out  1  feeder accepts word.
REQ-009 M_AXI_AWADDR  out  32  write address.
REQ-010 M_AXI_AWVALID  out  1  write address valid.
REQ-011 M_AXI_AWREADY  in  1  write address ready.
REQ-012 M_AXI_WDATA  out  32  write data.
REQ-013 M_AXI_WSTRB  out  4  write strobes.
REQ-014 M_AXI_WVALID  out  1  write data valid.
REQ-015 M_AXI_WREADY  in  1  write data ready.
REQ-016 M_AXI_BRESP  in  2  write response.
REQ-017 M_AXI_BVALID  in  1  write response valid.
REQ-018 M_AXI_BREADY  out  1  write response ready.
REQ-019 M_AXI_ARADDR  out  32  read address.
REQ-020 M_AXI_ARVALID  out  1  read address valid.
REQ-021 M_AXI_ARREADY  in  1  read address ready.
REQ-022 M_AXI_RDATA  in  32  read data.
REQ-023 M_AXI_RRESP  in  2  read response.
REQ-024 M_AXI_RVALID  in  1  read data valid.
REQ-025 M_AXI_RREADY  out  1  read data ready.
REQ-026 ERR  out  1  sticky flag: any BRESP or RRESP other than OKAY (2'b00).

Function
REQ-027 States IDLE, STAT_AR, STAT_R, GAP, WR, WR_B; exactly one AXI transaction outstanding at any time.
REQ-028 IDLE: S_TREADY=1 (registered, only in IDLE); on S_TVALID&S_TREADY latch S_TDATA, next state STAT_AR (WR when macro absent).
REQ-029 STAT_AR: ARVALID=1, ARADDR=C_BASE_ADDR+4, held until ARREADY; then STAT_R with RREADY=1 until RVALID.
REQ-030 STAT_R on RVALID: RRESP!=OKAY -> set ERR, drop word, IDLE; RDATA[C_FULL_BIT]=1 -> GAP; else -> WR.
REQ-031 GAP: down-counter loaded with C_POLL_GAP, all AXI valids low; at zero -> STAT_AR; unlimited retries.
REQ-032 WR: AWVALID and WVALID asserted same cycle, AWADDR=C_BASE_ADDR, WDATA=latched word, WSTRB=4'hF; each valid deasserts the cycle after its own handshake; both done -> WR_B.
REQ-033 AW and W handshakes in either order or same cycle SHALL be accepted; no valid depends combinationally on any ready.
REQ-034 WR_B: BREADY=1 until BVALID; BRESP!=OKAY sets ERR; word not retried; -> IDLE.
REQ-035 Latency: word accepted at edge N -> first ARVALID (or AWVALID, macro absent) high in cycle N+1.
REQ-036 Address/data outputs stable while corresponding valid high; ARADDR/AWADDR constant values.
REQ-037 ERR set stays 1 until ARESET; processing continues after error.

Reset
REQ-038 ARESET high at an edge: state IDLE, S_TREADY=0, all AXI valid/ready outputs 0, ERR=0, GAP counter 0; S_TREADY=1 first edge after release.
REQ-039 Reset mid-transaction SHALL abort immediately; in-flight word discarded, no completion waited for.

Configuration
REQ-040 Macro TX_FIFO_FEEDER_STATUS_POLL_EN: defined -> STAT_AR/STAT_R/GAP path per REQ-029..031 before every write; undefined -> those states and GAP counter not compiled, IDLE goes directly to WR, no AR/R traffic, ARVALID/RREADY tied 0.

Verification
REQ-041 ARESET high 3 cycles -> all valids/readies 0, ERR=0; first cycle after release S_TREADY=1.
REQ-042 Word 0x0101FFFF, STATUS RDATA=0 -> one AR to C_BASE_ADDR+4, then one AW/W to C_BASE_ADDR with WDATA=0x0101FFFF, WSTRB=4'hF; S_TREADY high after B.
REQ-043 STATUS RDATA=1 twice then 0 -> three AR transactions each separated by >=8 idle cycles, then exactly one write of word 0xabcd0001.
REQ-044 WREADY immediate, AWREADY delayed 3 cycles -> WVALID low after W handshake, AWVALID held 4 cycles, single B handshake.
REQ-045 BRESP=2'b10 on word 0xdeadbeef -> ERR=1 and stays 1; next word 0xbeef0011 written normally.
REQ-046 Macro undefined, 4 back-to-back words -> 4 writes in order, zero ARVALID assertions.

Source files
------------

// File: rtl/tx_fifo_axil_feeder.sv
// rtl/tx_fifo_axil_feeder.sv - stream-to-AXI-Lite feeder for a TX FIFO slave, one transaction in flight.
// Optional STATUS polling before each write: TX_FIFO_FEEDER_STATUS_POLL_EN.
module tx_fifo_axil_feeder #(
  parameter logic [31:0] C_BASE_ADDR = 32'h43C0_0000,
  parameter int unsigned C_POLL_GAP  = 8,
  parameter int unsigned C_FULL_BIT  = 0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] S_TDATA,
  input  logic        S_TVALID,
  output logic        S_TREADY,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic        ERR
);

  typedef enum logic [2:0] {IDLE, STAT_AR, STAT_R, GAP, WR, WR_B} state_t;

  state_t      state_q, state_n;
  logic        tready_q, tready_n;
  logic        awvalid_q, awvalid_n;
  logic        wvalid_q, wvalid_n;
  logic        bready_q, bready_n;
  logic        aw_done_q, aw_done_n;
  logic        w_done_q, w_done_n;
  logic        err_q, err_n;
  logic [31:0] word_q, word_n;
  logic        unused_inputs;

`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
  logic        arvalid_q, arvalid_n;
  logic        rready_q, rready_n;
  logic [7:0]  gap_q, gap_n;
  assign unused_inputs = ^M_AXI_RDATA;
`else
  assign unused_inputs = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

  // All outputs come straight from registers, so no valid ever follows a ready combinationally.
  always_comb begin
    state_n   = state_q;
    tready_n  = tready_q;
    awvalid_n = awvalid_q;
    wvalid_n  = wvalid_q;
    bready_n  = bready_q;
    aw_done_n = aw_done_q;
    w_done_n  = w_done_q;
    err_n     = err_q;
    word_n    = word_q;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    arvalid_n = arvalid_q;
    rready_n  = rready_q;
    gap_n     = gap_q;
`endif
    case (state_q)
      IDLE: begin
        tready_n = 1'b1;
        if (S_TVALID && tready_q) begin
          word_n   = S_TDATA;
          tready_n = 1'b0;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
          state_n   = STAT_AR;
          arvalid_n = 1'b1;
`else
          state_n   = WR;
          awvalid_n = 1'b1;
          wvalid_n  = 1'b1;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
`endif
        end
      end
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
      STAT_AR: begin
        if (arvalid_q && M_AXI_ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = STAT_R;
        end
      end
      STAT_R: begin
        if (rready_q && M_AXI_RVALID) begin
          rready_n = 1'b0;
          if (M_AXI_RRESP != 2'b00) begin
            err_n    = 1'b1;
            tready_n = 1'b1;
            state_n  = IDLE;
          end else if (M_AXI_RDATA[C_FULL_BIT]) begin
            gap_n   = 8'(C_POLL_GAP);
            state_n = GAP;
          end else begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            aw_done_n = 1'b0;
            w_done_n  = 1'b0;
            state_n   = WR;
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          gap_n     = 8'd0;
          arvalid_n = 1'b1;
          state_n   = STAT_AR;
        end else begin
          gap_n = gap_q - 8'd1;
        end
      end
`endif
      WR: begin
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_n = 1'b0;
          aw_done_n = 1'b1;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_n = 1'b0;
          w_done_n = 1'b1;
        end
        if (aw_done_n && w_done_n) begin
          bready_n = 1'b1;
          state_n  = WR_B;
        end
      end
      WR_B: begin
        if (bready_q && M_AXI_BVALID) begin
          bready_n = 1'b0;
          if (M_AXI_BRESP != 2'b00) err_n = 1'b1;
          tready_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      tready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      word_q    <= 32'd0;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      gap_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_n;
      tready_q  <= tready_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      aw_done_q <= aw_done_n;
      w_done_q  <= w_done_n;
      err_q     <= err_n;
      word_q    <= word_n;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      gap_q     <= gap_n;
`endif
    end
  end

  assign S_TREADY      = tready_q;
  assign M_AXI_AWADDR  = C_BASE_ADDR;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = word_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = C_BASE_ADDR + 32'd4;
  assign ERR           = err_q;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
`else
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fifo_axil_feeder.sv
// tb/tb_tx_fifo_axil_feeder.sv - directed self-checking bench for tx_fifo_axil_feeder with a small AXI-Lite slave.
module tb_tx_fifo_axil_feeder;
  localparam logic [31:0] BASE = 32'h43C0_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] S_TDATA = 32'd0;
  logic        S_TVALID = 1'b0;
  logic        S_TREADY;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, ERR;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
  logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
  logic [31:0] M_AXI_RDATA = 32'd0;

  always #5 ACLK = ~ACLK;

  tx_fifo_axil_feeder #(.C_BASE_ADDR(BASE), .C_POLL_GAP(8), .C_FULL_BIT(0)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .ERR(ERR)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] strb;} wr_t;
  wr_t         wr_q[$];
  logic [31:0] status_q[$];
  int          aw_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;

  logic        aw_v_p, aw_r_p, w_v_p, w_r_p, b_v_p, b_r_p, ar_v_p, ar_r_p, r_v_p, r_r_p;
  logic [31:0] aw_addr_p, w_data_p, ar_addr_p, cap_addr, cap_data, ar_last_addr;
  logic [3:0]  w_strb_p, cap_strb;
  logic        aw_got, w_got;
  int          cyc = 0, aw_cnt = 0, aw_high = 0, aw_hold_last = 0, hs_bad = 0;
  int          ar_cnt = 0, ar_high = 0, ar_last_cyc = 0, ar_min_gap = 1000;

  // Slave model: everything is decided on the falling edge from the values held over the last rising edge.
  always @(negedge ACLK) begin
    cyc++;
    if (ARESET) begin
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
      M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
      aw_got = 1'b0; w_got = 1'b0; aw_cnt = 0; aw_high = 0;
    end else begin
      if (M_AXI_ARVALID) ar_high++;
      if (aw_v_p && aw_r_p) begin
        aw_got = 1'b1; cap_addr = aw_addr_p;
        aw_hold_last = aw_high; aw_high = 0; aw_cnt = 0;
        if (M_AXI_AWVALID) hs_bad++;
      end
      if (w_v_p && w_r_p) begin
        w_got = 1'b1; cap_data = w_data_p; cap_strb = w_strb_p;
        if (M_AXI_WVALID) hs_bad++;
      end
      if (b_v_p && b_r_p) begin
        wr_q.push_back('{cap_addr, cap_data, cap_strb});
        M_AXI_BVALID = 1'b0; aw_got = 1'b0; w_got = 1'b0;
      end else if (aw_got && w_got && !M_AXI_BVALID) begin
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp_cfg;
      end
      if (ar_v_p && ar_r_p) begin
        ar_cnt++;
        ar_last_addr = ar_addr_p;
        if (ar_cnt > 1 && (cyc - ar_last_cyc) < ar_min_gap) ar_min_gap = cyc - ar_last_cyc;
        ar_last_cyc = cyc;
        M_AXI_RVALID = 1'b1; M_AXI_RRESP = 2'b00;
        M_AXI_RDATA = (status_q.size() > 0) ? status_q.pop_front() : 32'd0;
      end else if (r_v_p && r_r_p) begin
        M_AXI_RVALID = 1'b0;
      end
      if (M_AXI_AWVALID) begin
        aw_high++;
        if (aw_cnt >= aw_delay) M_AXI_AWREADY = 1'b1;
        else begin M_AXI_AWREADY = 1'b0; aw_cnt++; end
      end else begin
        M_AXI_AWREADY = 1'b0;
      end
      M_AXI_WREADY  = M_AXI_WVALID;
      M_AXI_ARREADY = M_AXI_ARVALID;
    end
    aw_v_p = M_AXI_AWVALID; aw_r_p = M_AXI_AWREADY; aw_addr_p = M_AXI_AWADDR;
    w_v_p = M_AXI_WVALID; w_r_p = M_AXI_WREADY; w_data_p = M_AXI_WDATA; w_strb_p = M_AXI_WSTRB;
    b_v_p = M_AXI_BVALID; b_r_p = M_AXI_BREADY;
    ar_v_p = M_AXI_ARVALID; ar_r_p = M_AXI_ARREADY; ar_addr_p = M_AXI_ARADDR;
    r_v_p = M_AXI_RVALID; r_r_p = M_AXI_RREADY;
  end

  task automatic send_word(input logic [31:0] d);
    int   t;
    logic hs;
    t = 0; hs = 1'b0;
    S_TDATA = d; S_TVALID = 1'b1;
    while (!hs && t < 200) begin
      hs = S_TREADY;
      @(negedge ACLK);
      t++;
    end
    S_TVALID = 1'b0;
    chk("s_accept", {31'd0, hs}, 32'd1);
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    chk("latency_arvalid", {31'd0, M_AXI_ARVALID}, 32'd1);
`else
    chk("latency_awvalid", {31'd0, M_AXI_AWVALID}, 32'd1);
`endif
  endtask

  task automatic wait_writes(input int n);
    int t;
    t = 0;
    while (wr_q.size() < n && t < 400) begin
      @(negedge ACLK);
      t++;
    end
    chk("write_count", wr_q.size(), n);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [31:0] data);
    if (idx < wr_q.size()) begin
      chk({tag, "_addr"}, wr_q[idx].addr, BASE);
      chk({tag, "_data"}, wr_q[idx].data, data);
      chk({tag, "_strb"}, {28'd0, wr_q[idx].strb}, 32'h0000_000F);
    end else begin
      chk({tag, "_missing"}, wr_q.size(), idx + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nw;
    int          ar0;
    logic [31:0] words [4];
    words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
    words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
    nw = 0;

    ARESET = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("rst_outputs", {26'd0, S_TREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                        M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("tready_after_release", {31'd0, S_TREADY}, 32'd1);

    ar0 = ar_cnt;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    status_q.push_back(32'd0);
`endif
    send_word(32'h0101_FFFF);
    nw++; wait_writes(nw);
    chk_write("basic", nw - 1, 32'h0101_FFFF);
    chk("tready_after_b", {31'd0, S_TREADY}, 32'd1);
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    chk("basic_ar_count", ar_cnt - ar0, 32'd1);
    chk("basic_ar_addr", ar_last_addr, BASE + 32'd4);

    ar0 = ar_cnt;
    ar_min_gap = 1000;
    status_q.push_back(32'd1); status_q.push_back(32'd1); status_q.push_back(32'd0);
    send_word(32'habcd_0001);
    nw++; wait_writes(nw);
    repeat (20) @(negedge ACLK);
    chk("poll_ar_count", ar_cnt - ar0, 32'd3);
    chk("poll_gap_ge9", {31'd0, ar_min_gap >= 9}, 32'd1);
    chk("poll_one_write", wr_q.size(), nw);
    chk_write("poll", nw - 1, 32'habcd_0001);
`endif

    aw_delay = 3; hs_bad = 0;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    status_q.push_back(32'd0);
`endif
    send_word(32'h5a5a_0044);
    nw++; wait_writes(nw);
    repeat (10) @(negedge ACLK);
    chk("awdelay_hold", aw_hold_last, 32'd4);
    chk("valid_drop_after_hs", hs_bad, 32'd0);
    chk("awdelay_single_b", wr_q.size(), nw);
    chk_write("awdelay", nw - 1, 32'h5a5a_0044);
    aw_delay = 0;

    bresp_cfg = 2'b10;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    status_q.push_back(32'd0); status_q.push_back(32'd0);
`endif
    send_word(32'hdead_beef);
    nw++; wait_writes(nw);
    chk("err_set", {31'd0, ERR}, 32'd1);
    bresp_cfg = 2'b00;
    send_word(32'hbeef_0011);
    nw++; wait_writes(nw);
    chk_write("after_err", nw - 1, 32'hbeef_0011);
    chk("err_sticky", {31'd0, ERR}, 32'd1);

    ar0 = ar_cnt;
    foreach (words[i]) begin
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
      status_q.push_back(32'd0);
`endif
      send_word(words[i]);
    end
    wait_writes(nw + 4);
    for (int i = 0; i < 4; i++) chk_write($sformatf("b2b%0d", i), nw + i, words[i]);
    nw += 4;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    chk("b2b_ar_count", ar_cnt - ar0, 32'd4);
`else
    chk("no_arvalid_ever", ar_high, 32'd0);
`endif

    aw_delay = 50;
`ifdef TX_FIFO_FEEDER_STATUS_POLL_EN
    status_q.push_back(32'd0);
`endif
    send_word(32'h7777_0000);
    repeat (3) @(negedge ACLK);
    chk("midrst_aw_pending", {31'd0, M_AXI_AWVALID}, 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("midrst_outputs", {26'd0, S_TREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                           M_AXI_ARVALID, M_AXI_RREADY}, 32'd0);
    chk("midrst_err_clear", {31'd0, ERR}, 32'd0);
    ARESET = 1'b0; aw_delay = 0;
    status_q.delete();
    @(negedge ACLK);
    chk("midrst_tready", {31'd0, S_TREADY}, 32'd1);
    repeat (20) @(negedge ACLK);
    chk("midrst_word_dropped", wr_q.size(), nw);
    chk("midrst_idle_awvalid", {31'd0, M_AXI_AWVALID}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
